// File: rtl/cpu_trace_recorder.sv
// cpu_trace_recorder: snoops the single-cycle CPU's PC, register-file writes
// and data-memory writes, logging commit events with a cycle stamp into a
// DEPTH-entry show-ahead buffer drained through the rd_* port. A sticky done
// flag is raised on a PC self-loop halt or when the cycle budget runs out.
// Optional feature macro: TRACE_WRAP_EN -- when defined the full buffer acts as
// a flight recorder (oldest entry overwritten); otherwise new entries are
// discarded while full. Either way every lost event bumps drop_cnt_o.
// Read port handshake: rd_valid_o is high whenever an entry is stored and the
// head fields are then meaningful; the head is popped on a clock edge where
// rd_en_i && rd_valid_o, and rd_en_i while empty has no effect.
module cpu_trace_recorder #(
    parameter int DATA_W      = 32,
    parameter int PC_W        = 32,
    parameter int MADDR_W     = 32,
    parameter int DEPTH       = 16,
    parameter int CYC_W       = 16,
    parameter int HALT_CYCLES = 4,
    parameter int MAX_CYCLES  = 320
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [PC_W-1:0]            pc_i,
    input  logic                       reg_we_i,
    input  logic [4:0]                 reg_addr_i,
    input  logic [DATA_W-1:0]          reg_wdata_i,
    input  logic                       mem_we_i,
    input  logic [MADDR_W-1:0]         mem_addr_i,
    input  logic [DATA_W-1:0]          mem_wdata_i,
    input  logic                       rd_en_i,
    output logic                       rd_valid_o,
    output logic [CYC_W-1:0]           rd_cycle_o,
    output logic [PC_W-1:0]            rd_pc_o,
    output logic [1:0]                 rd_flags_o,
    output logic [4:0]                 rd_reg_addr_o,
    output logic [DATA_W-1:0]          rd_reg_data_o,
    output logic [MADDR_W-1:0]         rd_mem_addr_o,
    output logic [DATA_W-1:0]          rd_mem_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [15:0]                drop_cnt_o,
    output logic [CYC_W-1:0]           cycle_o,
    output logic                       done_o
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int SW    = $clog2(HALT_CYCLES + 1);

    typedef struct packed {
        logic [CYC_W-1:0]   cycle;
        logic [PC_W-1:0]    pc;
        logic [1:0]         flags;
        logic [4:0]         reg_addr;
        logic [DATA_W-1:0]  reg_data;
        logic [MADDR_W-1:0] mem_addr;
        logic [DATA_W-1:0]  mem_data;
    } entry_t;

    entry_t buf_mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      drop_q, drop_d;
    logic [CYC_W-1:0] cycle_q, cycle_d;
    logic             done_q, done_d;
    logic [PC_W-1:0]  pc_prev_q, pc_prev_d;
    logic [SW-1:0]    stall_q, stall_d;

    logic   reg_ev, mem_ev, push, pop, full, overflow, wr_en;
    entry_t new_entry;

    assign reg_ev = reg_we_i && (reg_addr_i != 5'd0);
    assign mem_ev = mem_we_i;
    assign push   = !done_q && (reg_ev || mem_ev);
    assign pop    = rd_en_i && (count_q != '0);
    assign full   = (count_q == CNT_W'(DEPTH));

    assign new_entry = '{cycle: cycle_q, pc: pc_i, flags: {mem_ev, reg_ev},
                         reg_addr: reg_addr_i, reg_data: reg_wdata_i,
                         mem_addr: mem_addr_i, mem_data: mem_wdata_i};

    // Next-state: buffer pointers/occupancy, drop counter, cycle stamp, halt detect
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        drop_d    = drop_q;
        cycle_d   = cycle_q;
        done_d    = done_q;
        pc_prev_d = pc_i;
        stall_d   = '0;
        overflow  = 1'b0;
        wr_en     = 1'b0;

        if (push && full && !pop) begin
            overflow = 1'b1;
`ifdef TRACE_WRAP_EN
            // Overwrite the oldest entry; the head moves past it, count stays DEPTH
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            rd_ptr_d = rd_ptr_q + AW'(1);
`else
            // New entry is discarded; buffer contents untouched
`endif
        end else begin
            if (push) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end

        if (overflow && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end

        if (!done_q && (cycle_q != '1)) begin
            cycle_d = cycle_q + CYC_W'(1);
        end

        if (pc_i == pc_prev_q) begin
            stall_d = (stall_q == '1) ? stall_q : stall_q + SW'(1);
        end

        if ((stall_d == SW'(HALT_CYCLES)) || (cycle_q == CYC_W'(MAX_CYCLES - 1))) begin
            done_d = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            drop_q    <= '0;
            cycle_q   <= '0;
            done_q    <= 1'b0;
            pc_prev_q <= '0;
            stall_q   <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            drop_q    <= drop_d;
            cycle_q   <= cycle_d;
            done_q    <= done_d;
            pc_prev_q <= pc_prev_d;
            stall_q   <= stall_d;
        end
    end

    // Trace storage; contents are not cleared by reset
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            buf_mem[wr_ptr_q] <= new_entry;
        end
    end

    assign rd_valid_o    = (count_q != '0);
    assign rd_cycle_o    = buf_mem[rd_ptr_q].cycle;
    assign rd_pc_o       = buf_mem[rd_ptr_q].pc;
    assign rd_flags_o    = buf_mem[rd_ptr_q].flags;
    assign rd_reg_addr_o = buf_mem[rd_ptr_q].reg_addr;
    assign rd_reg_data_o = buf_mem[rd_ptr_q].reg_data;
    assign rd_mem_addr_o = buf_mem[rd_ptr_q].mem_addr;
    assign rd_mem_data_o = buf_mem[rd_ptr_q].mem_data;
    assign count_o       = count_q;
    assign full_o        = full;
    assign empty_o       = (count_q == '0);
    assign drop_cnt_o    = drop_q;
    assign cycle_o       = cycle_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_cpu_trace_recorder.sv
// Bench for cpu_trace_recorder: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of the trace buffer.
module tb_cpu_trace_recorder;
    localparam int DEPTH       = 16;
    localparam int HALT_CYCLES = 4;
    localparam int MAX_CYCLES  = 320;

    logic        clk, rst_n;
    logic [31:0] pc_i;
    logic        reg_we, mem_we, rd_en;
    logic [4:0]  reg_addr;
    logic [31:0] reg_wdata, mem_addr, mem_wdata;
    logic        rd_valid_o, full_o, empty_o, done_o;
    logic [15:0] rd_cycle_o, drop_cnt_o, cycle_o;
    logic [31:0] rd_pc_o, rd_reg_data_o, rd_mem_addr_o, rd_mem_data_o;
    logic [1:0]  rd_flags_o;
    logic [4:0]  rd_reg_addr_o;
    logic [4:0]  count_o;

    cpu_trace_recorder dut (
        .clk_i(clk), .rst_i(rst_n), .pc_i(pc_i),
        .reg_we_i(reg_we), .reg_addr_i(reg_addr), .reg_wdata_i(reg_wdata),
        .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .rd_en_i(rd_en), .rd_valid_o(rd_valid_o), .rd_cycle_o(rd_cycle_o),
        .rd_pc_o(rd_pc_o), .rd_flags_o(rd_flags_o), .rd_reg_addr_o(rd_reg_addr_o),
        .rd_reg_data_o(rd_reg_data_o), .rd_mem_addr_o(rd_mem_addr_o),
        .rd_mem_data_o(rd_mem_data_o), .count_o(count_o), .full_o(full_o),
        .empty_o(empty_o), .drop_cnt_o(drop_cnt_o), .cycle_o(cycle_o), .done_o(done_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    typedef struct {
        logic [15:0] cycle;
        logic [31:0] pc;
        logic [1:0]  flags;
        logic [4:0]  ra;
        logic [31:0] rd;
        logic [31:0] ma;
        logic [31:0] md;
    } ent_t;

    ent_t        exp_q[$];
    int          m_cycle, m_drop, m_stall;
    bit          m_done;
    logic [31:0] m_pc_prev;
    logic [31:0] drv_pc;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_cycle   = 0;
        m_drop    = 0;
        m_stall   = 0;
        m_done    = 1'b0;
        m_pc_prev = '0;
    endtask

    // Reference model: advances on every active edge out of reset
    always @(posedge clk) begin
        if (rst_n) begin
            bit   ev_r, push, pop, nd;
            int   stall_n;
            ent_t e;
            ev_r    = reg_we && (reg_addr != 5'd0);
            push    = !m_done && (ev_r || mem_we);
            pop     = rd_en && (exp_q.size() > 0);
            e.cycle = m_cycle[15:0];
            e.pc    = pc_i;
            e.flags = {mem_we, ev_r};
            e.ra    = reg_addr;
            e.rd    = reg_wdata;
            e.ma    = mem_addr;
            e.md    = mem_wdata;
            if (pop) void'(exp_q.pop_front());
            if (push) begin
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back(e);
                end else begin
                    if (m_drop < 65535) m_drop++;
`ifdef TRACE_WRAP_EN
                    void'(exp_q.pop_front());
                    exp_q.push_back(e);
`endif
                end
            end
            stall_n = (pc_i == m_pc_prev) ? m_stall + 1 : 0;
            nd = m_done || (stall_n == HALT_CYCLES) || (m_cycle == MAX_CYCLES - 1);
            if (!m_done && m_cycle < 65535) m_cycle++;
            m_stall   = (stall_n > 1000) ? 1000 : stall_n;
            m_pc_prev = pc_i;
            m_done    = nd;
        end
    end

    // Monitor: compares DUT status and head entry against the model on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("count", count_o, exp_q.size());
            chk("empty", empty_o, exp_q.size() == 0);
            chk("full", full_o, exp_q.size() == DEPTH);
            chk("rd_valid", rd_valid_o, exp_q.size() != 0);
            chk("drop_cnt", drop_cnt_o, m_drop);
            chk("cycle", cycle_o, m_cycle);
            chk("done", done_o, m_done);
            if (rd_valid_o && exp_q.size() > 0) begin
                chk("head_cycle", rd_cycle_o, exp_q[0].cycle);
                chk("head_pc", rd_pc_o, exp_q[0].pc);
                chk("head_flags", rd_flags_o, exp_q[0].flags);
                chk("head_reg_addr", rd_reg_addr_o, exp_q[0].ra);
                chk("head_reg_data", rd_reg_data_o, exp_q[0].rd);
                chk("head_mem_addr", rd_mem_addr_o, exp_q[0].ma);
                chk("head_mem_data", rd_mem_data_o, exp_q[0].md);
            end
        end
    end

    task automatic set_idle();
        reg_we    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rd_en     = 1'b0;
    endtask

    // Asynchronous reset applied mid-cycle; reset values checked immediately
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_clear();
        set_idle();
        drv_pc = 32'h100;
        pc_i   = drv_pc;
        #1;
        chk("rst_count", count_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_valid", rd_valid_o, 0);
        chk("rst_drop", drop_cnt_o, 0);
        chk("rst_cycle", cycle_o, 0);
        chk("rst_done", done_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Driver: applies one cycle of inputs (from a falling edge to the next)
    task automatic do_cycle(input bit rwe, input logic [4:0] ra, input logic [31:0] rdat,
                            input bit mwe, input logic [31:0] ma, input logic [31:0] md,
                            input bit ren, input bit hold_pc);
        pc_i      = drv_pc;
        reg_we    = rwe;
        reg_addr  = ra;
        reg_wdata = rdat;
        mem_we    = mwe;
        mem_addr  = ma;
        mem_wdata = md;
        rd_en     = ren;
        @(negedge clk);
        if (!hold_pc) drv_pc = drv_pc + 32'd4;
        set_idle();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic random_run(input int n, input int pop_pct);
        for (int i = 0; i < n; i++) begin
            do_cycle($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom(),
                     ($urandom_range(0, 3) == 0), $urandom(), $urandom(),
                     ($urandom_range(0, 99) < pop_pct), ($urandom_range(0, 7) == 0));
        end
    endtask

    initial begin
        rst_n = 1'b1;
        drv_pc = 32'h100;
        pc_i = drv_pc;
        set_idle();
        model_clear();
        @(negedge clk);

        // Reg write R8=5 stamped at cycle 3, visible on the next cycle
        do_reset();
        idle_cycles(3);
        do_cycle(1, 5'd8, 32'd5, 0, 0, 0, 0, 0);
        chk("t1_valid", rd_valid_o, 1);
        chk("t1_cycle", rd_cycle_o, 3);
        chk("t1_flags", rd_flags_o, 2'b01);
        chk("t1_data", rd_reg_data_o, 5);

        // Reg and mem write in one cycle share one entry
        do_reset();
        do_cycle(1, 5'd2, 32'd7, 1, 32'd12, 32'd9, 0, 0);
        chk("t2_flags", rd_flags_o, 2'b11);
        chk("t2_count", count_o, 1);
        chk("t2_maddr", rd_mem_addr_o, 12);

        // R0 writes are not logged
        do_reset();
        do_cycle(1, 5'd0, 32'hDEAD, 0, 0, 0, 0, 0);
        chk("t3_count", count_o, 0);
        chk("t3_drop", drop_cnt_o, 0);

        // 18 events into a 16-entry buffer with no pops
        do_reset();
        for (int i = 0; i < 18; i++) do_cycle(1, 5'd3, 32'(i), 0, 0, 0, 0, 0);
        chk("t4_full", full_o, 1);
        chk("t4_drop", drop_cnt_o, 2);
`ifdef TRACE_WRAP_EN
        chk("t4_head_cycle", rd_cycle_o, 2);
`else
        chk("t4_head_cycle", rd_cycle_o, 0);
`endif
        // Full with simultaneous push and pop, then drain
        do_cycle(1, 5'd4, 32'h44, 0, 0, 0, 1, 0);
        chk("t4_pushpop_count", count_o, 16);
        for (int i = 0; i < 18; i++) do_cycle(0, 0, 0, 0, 0, 0, 1, 0);
        chk("t4_drained", empty_o, 1);

        // PC held at 0x20 from cycle 10: halt after HALT_CYCLES stalled edges
        do_reset();
        idle_cycles(10);
        drv_pc = 32'h20;
        for (int i = 0; i < 8; i++) do_cycle(1, 5'd1, 32'(100 + i), 0, 0, 0, 0, 1);
        chk("t5_done", done_o, 1);
        chk("t5_cycle", cycle_o, 15);
        chk("t5_count", count_o, 5);
        for (int i = 0; i < 6; i++) do_cycle(0, 0, 0, 0, 0, 0, 1, 0);
        chk("t5_popped_after_done", count_o, 0);

        // Reset pulsed mid-stream with 5 entries stored
        do_reset();
        for (int i = 0; i < 5; i++) do_cycle(0, 0, 0, 1, 32'(i * 4), 32'(i), 0, 0);
        chk("t6_count_before", count_o, 5);
        do_reset();

        // Random traffic long enough to hit the cycle budget
        random_run(MAX_CYCLES + 20, 35);
        do_reset();
        random_run(200, 70);
        do_reset();
        random_run(150, 10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
